// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a show-ahead FIFO; optional parity check when UART_RX_PARITY_EN is defined.
// A character reaches the FIFO one cycle after its stop-bit sample; the line cannot be stalled, so a full FIFO drops the character and pulses overrun.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          uartRx_pin,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rx_sync;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] push_dat_q, push_dat_d;
  logic                 push_q, push_d;
  logic                 fe_req_q, fe_req_d;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 pop_req;
  logic                 fifo_full;
  logic                 fifo_empty;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_q, par_d;
  logic pe_req_q, pe_req_d;
  logic parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uartRx_pin;
      sync2_q <= sync1_q;
    end
  end
  assign rx_sync = sync2_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    push_dat_d = push_dat_q;
    fe_req_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_req_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!rx_sync) begin
          state_d = S_START;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ rx_sync;
`endif
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        // par_q ends up 1 exactly when the received parity is wrong.
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          par_d   = par_q ^ rx_sync ^ PAR_ODD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == BIT_M1) begin
          baud_d = '0;
          if (!rx_sync) begin
            fe_req_d = 1'b1;
            state_d  = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_q) begin
            pe_req_d = 1'b1;
            state_d  = S_IDLE;
`endif
          end else begin
            push_d     = 1'b1;
            push_dat_d = shift_q;
            state_d    = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        baud_d = '0;
        if (rx_sync) state_d = S_IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
      fe_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      push_dat_q <= push_dat_d;
      fe_req_q   <= fe_req_d;
    end
  end

  // Error pulses share the cycle with the FIFO write so the decoder sees one event per character.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= fe_req_q;
      overrun_q   <= push_q && fifo_full && !pop_req;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      par_q        <= 1'b0;
      pe_req_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      pe_req_q     <= pe_req_d;
      parity_err_q <= pe_req_q;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign pop_req = rd_en && !fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .push_i     (push_q),
    .push_dat_i (push_dat_q),
    .pop_i      (pop_req),
    .head_dat_o (rd_data),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rd_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames are driven bit by bit and a queue model predicts FIFO state and pulses per cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int K_GOOD  = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  typedef struct packed {
    int            edge_n;
    int            kind;
    logic [DB-1:0] dat;
  } ev_t;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          uartRx_pin = 1'b1;
  logic          rd_en = 1'b0;
  logic [DB-1:0] rd_data;
  logic          rd_valid;
  logic [2:0]    fifo_count;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [DB-1:0] mq[$];
  ev_t           evq[$];
  logic          e_fe = 1'b0, e_pe = 1'b0, e_ov = 1'b0;
  int            fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int            rise_cyc = 0;
  logic          prev_valid = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH),
    .PARITY_ODD   (0)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .uartRx_pin (uartRx_pin),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Model: a queue of stored characters plus a list of (edge, outcome) events from the frames sent.
  initial begin
    forever begin
      ev_t ev;
      @(posedge CLK);
      cyc++;
      e_fe = 1'b0;
      e_pe = 1'b0;
      e_ov = 1'b0;
      if (Reset) begin
        mq.delete();
        evq.delete();
      end else begin
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        while (evq.size() > 0 && evq[0].edge_n <= cyc) begin
          ev = evq.pop_front();
          if (ev.edge_n == cyc) begin
            if (ev.kind == K_FRAME) e_fe = 1'b1;
            else if (ev.kind == K_PAR) e_pe = 1'b1;
            else if (mq.size() < DEPTH) mq.push_back(ev.dat);
            else e_ov = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      int exp_v, exp_d, exp_c;
      @(negedge CLK);
      if (rd_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rd_valid;
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
      if (Reset) begin
        exp_v = 0; exp_d = 0; exp_c = 0;
        chk("frame_err", frame_err, 0);
        chk("parity_err", parity_err, 0);
        chk("overrun", overrun, 0);
      end else begin
        exp_c = mq.size();
        exp_v = (exp_c > 0) ? 1 : 0;
        exp_d = (exp_c > 0) ? int'(mq[0]) : 0;
        chk("frame_err", frame_err, int'(e_fe));
        chk("parity_err", parity_err, int'(e_pe));
        chk("overrun", overrun, int'(e_ov));
      end
      chk("rd_valid", rd_valid, exp_v);
      chk("rd_data", rd_data, exp_d);
      chk("fifo_count", fifo_count, exp_c);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame starting now; registers its outcome at the edge the FIFO/pulses must change.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_bit, input bit par_flip,
                            input bit pop_at_push, output int c0);
    bit   fb[DB+3];
    int   nbits;
    bit   p;
    ev_t  ev;
    nbits = DB + 2 + PBITS;
    fb[0] = 1'b0;
    for (int i = 0; i < DB; i++) fb[1+i] = d[i];
    p = (^d) ^ par_flip;
    if (PBITS != 0) fb[DB+1] = p;
    fb[nbits-1] = stop_bit;
    c0 = cyc;
    ev.edge_n = c0 + 4 + HALF + (DB + 1 + PBITS) * CPB;
    ev.kind   = !stop_bit ? K_FRAME : ((PBITS != 0 && par_flip) ? K_PAR : K_GOOD);
    ev.dat    = d;
    evq.push_back(ev);
    for (int b = 0; b < nbits; b++) begin
      uartRx_pin = fb[b];
      for (int k = 0; k < CPB; k++) begin
        if (pop_at_push) rd_en = (cyc == ev.edge_n - 1);
        tick(1);
      end
    end
    if (pop_at_push) rd_en = 1'b0;
  endtask

  task automatic drain_expect(input string nm, input logic [DB-1:0] v);
    chk({nm, "_vld"}, rd_valid, 1);
    chk(nm, rd_data, v);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int c0;
    int saved;
    #1 Reset = 1'b1;
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_pulses", {frame_err, parity_err, overrun}, 0);
    tick(3);
    Reset = 1'b0;
    tick(5);

    // Single character; stop sample lands 155 cycles after pin drive, FIFO updates on the next edge.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, c0);
    tick(2);
    chk("first_rise_delay", rise_cyc - c0, (PBITS != 0) ? 172 : 156);
    chk("single_count", fifo_count, 1);
    drain_expect("single_data", 8'h55);
    chk("single_empty_vld", rd_valid, 0);
    chk("single_empty_cnt", fifo_count, 0);
    rd_en = 1'b1;
    tick(2);
    rd_en = 1'b0;
    chk("pop_empty_cnt", fifo_count, 0);

    // Back-to-back burst into a 4-deep FIFO.
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'hB1, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, c0);
    tick(CPB);
    chk("burst_count", fifo_count, 4);
    chk("burst_overruns", ov_cnt, 1);
    drain_expect("burst_d0", 8'hFF);
    drain_expect("burst_d1", 8'h55);
    drain_expect("burst_d2", 8'h01);
    drain_expect("burst_d3", 8'hB1);
    chk("burst_drained", fifo_count, 0);

    // Low stop bit, line held low, then a good character.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, c0);
    tick(30 * CPB);
    uartRx_pin = 1'b1;
    tick(2 * CPB);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, c0);
    tick(CPB);
    chk("break_frame_errs", fe_cnt, 1);
    chk("break_count", fifo_count, 1);
    drain_expect("break_data", 8'hA5);

    // Short glitch is rejected in START.
    saved = fe_cnt + pe_cnt + ov_cnt;
    uartRx_pin = 1'b0;
    tick(3);
    uartRx_pin = 1'b1;
    tick(12 * CPB);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_pulses", fe_cnt + pe_cnt + ov_cnt, saved);

    // Push and pop together at count 1.
    send_frame(8'h21, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b1, c0);
    tick(CPB);
    chk("cnt1_pushpop_count", fifo_count, 1);
    drain_expect("cnt1_pushpop_data", 8'h42);

    // Push and pop together at full: no overrun, new byte read out last.
    send_frame(8'h10, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h20, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h30, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h40, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h50, 1'b1, 1'b0, 1'b1, c0);
    tick(CPB);
    chk("full_pushpop_count", fifo_count, 4);
    chk("full_pushpop_overruns", ov_cnt, 1);
    drain_expect("full_d0", 8'h20);
    drain_expect("full_d1", 8'h30);
    drain_expect("full_d2", 8'h40);
    drain_expect("full_d3", 8'h50);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, c0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, c0);
    tick(CPB);
    chk("parity_errs", pe_cnt, 1);
    chk("parity_count", fifo_count, 1);
    drain_expect("parity_data", 8'h07);
`endif

    // Reset in the middle of a data bit, with one character already buffered.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, c0);
    tick(2);
    chk("pre_reset_count", fifo_count, 1);
    uartRx_pin = 1'b0;
    tick(2 * CPB + CPB / 2);
    Reset = 1'b1;
    uartRx_pin = 1'b1;
    #1;
    chk("mid_reset_count", fifo_count, 0);
    chk("mid_reset_valid", rd_valid, 0);
    tick(3);
    Reset = 1'b0;
    tick(12 * CPB);
    chk("post_reset_count", fifo_count, 0);
    chk("post_reset_valid", rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
